apb_master_bridge: RTL

Converts a single vmicro16 core's load/store request into an APB3 transfer (SETUP phase, then ACCESS phase) and drives one master port of the APB interconnect. It sits between the core's memory stage and one `S_*` slot of the interconnect. It registers the address, write data and direction for the whole transfer, inserts wait states while `M_PREADY` is low, and returns read data with a one-cycle completion pulse. One instance is built per core.

---
 rtl/vmicro16_apb_pkg.sv | 22 ++
 rtl/apb_master_timeout.sv | 33 +++
 rtl/apb_master_bridge.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vmicro16_apb_pkg.sv
// Shared APB definitions for the vmicro16 bridge and interconnect decode.
// The timeout feature is enabled by defining APB_MASTER_TIMEOUT_EN.
package vmicro16_apb_pkg;

  typedef enum logic [1:0] {
    APB_M_IDLE   = 2'b00,
    APB_M_SETUP  = 2'b01,
    APB_M_ACCESS = 2'b10
  } apb_m_state_t;

  localparam int APB_M_TIMEOUT_DEFAULT = 255;
  localparam int APB_M_WAIT_CNT_W      = 16;

  // Peripheral window decoded by the interconnect; kept here so both sides agree.
  localparam logic [15:0] APB_PERIPH_BASE = 16'h0080;
  localparam logic [15:0] APB_PERIPH_LAST = 16'h00FF;

  function automatic logic apb_addr_in_window(input logic [15:0] addr);
    return (addr >= APB_PERIPH_BASE) && (addr <= APB_PERIPH_LAST);
  endfunction

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS-phase wait counter; flags expiry when the limit is reached with PREADY low.
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_timeout
  import vmicro16_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_M_TIMEOUT_DEFAULT,
  parameter int CNT_W          = APB_M_WAIT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic in_access,
  input  logic pready,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;

  // SETUP always precedes ACCESS, so clearing outside ACCESS clears on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!in_access) begin
      wait_cnt <= '0;
    end else if (!pready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign expired = in_access && !pready && (wait_cnt == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Core load/store to APB3 master bridge (SETUP then ACCESS, wait states on PREADY).
// Optional ACCESS timeout/abort is compiled in with APB_MASTER_TIMEOUT_EN.
//
// state        | meaning
// APB_M_IDLE   | bus released, waiting for a new core request
// APB_M_SETUP  | PSEL high, PENABLE low, one cycle
// APB_M_ACCESS | PSEL and PENABLE high, waiting for PREADY
module apb_master_bridge
  import vmicro16_apb_pkg::*;
#(
  parameter int BUS_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = APB_M_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 req_we,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic [BUS_WIDTH-1:0] M_PADDR,
  output logic                 M_PWRITE,
  output logic                 M_PSELx,
  output logic                 M_PENABLE,
  output logic [BUS_WIDTH-1:0] M_PWDATA,
  input  logic [BUS_WIDTH-1:0] M_PRDATA,
  input  logic                 M_PREADY
);

  apb_m_state_t state, state_nxt;
  logic         accept;
  logic         in_access;
  logic         complete;
  logic         abort;

  // A request still held in the done cycle belongs to the finished transfer.
  assign accept    = req && !done;
  assign in_access = (state == APB_M_ACCESS);
  assign complete  = in_access && M_PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (APB_M_WAIT_CNT_W)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .in_access (in_access),
    .pready    (M_PREADY),
    .expired   (abort)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= abort;
    end
  end
`else
  localparam int timeout_cycles_unused = TIMEOUT_CYCLES;

  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= APB_M_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      APB_M_IDLE: begin
        if (accept) begin
          state_nxt = APB_M_SETUP;
        end
      end
      APB_M_SETUP: begin
        state_nxt = APB_M_ACCESS;
      end
      APB_M_ACCESS: begin
        if (complete || abort) begin
          state_nxt = APB_M_IDLE;
        end
      end
      default: begin
        state_nxt = APB_M_IDLE;
      end
    endcase
  end

  // Decoded straight from the state register so reset drops the bus without a clock.
  always_comb begin
    M_PSELx   = 1'b0;
    M_PENABLE = 1'b0;
    busy      = 1'b0;
    case (state)
      APB_M_SETUP: begin
        M_PSELx = 1'b1;
        busy    = 1'b1;
      end
      APB_M_ACCESS: begin
        M_PSELx   = 1'b1;
        M_PENABLE = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        M_PSELx   = 1'b0;
        M_PENABLE = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      M_PADDR  <= '0;
      M_PWDATA <= '0;
      M_PWRITE <= 1'b0;
      rdata    <= '0;
      done     <= 1'b0;
    end else begin
      done <= complete || abort;
      if ((state == APB_M_IDLE) && accept) begin
        M_PADDR  <= req_addr;
        M_PWDATA <= req_wdata;
        M_PWRITE <= req_we;
      end
      if (complete && !M_PWRITE) begin
        rdata <= M_PRDATA;
      end
    end
  end

endmodule
